// File: rtl/shift_engine_if.sv
// Bus bundle for shift_engine: load/strobe controls, serial lines, parallel data and status.
interface shift_engine_if #(
    parameter int WIDTH = 8
);
    logic             peripheralClkEdge;
    logic             parallelLoad;
    logic [WIDTH-1:0] parallelDataIn;
    logic             serialDataIn;
    logic             msbFirst;
    logic [WIDTH-1:0] parallelDataOut;
    logic             serialDataOut;
    logic             busy;
    logic             frameDone;

    modport master (
        output peripheralClkEdge, parallelLoad, parallelDataIn, serialDataIn, msbFirst,
        input  parallelDataOut, serialDataOut, busy, frameDone
    );

    modport slave (
        input  peripheralClkEdge, parallelLoad, parallelDataIn, serialDataIn, msbFirst,
        output parallelDataOut, serialDataOut, busy, frameDone
    );
endinterface

// File: rtl/shift_engine.sv
// Bidirectional-order serial shift engine: loads a word, shifts WIDTH bits out while
// shifting serial data in, and pulses frameDone when the frame completes.
module shift_engine #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    shift_engine_if.slave bus
);
    localparam int COUNT_W = $clog2(WIDTH) + 1;
    localparam logic [COUNT_W-1:0] LAST_COUNT = COUNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   mem_reg, mem_next;
    logic               order_reg, order_next;
    logic [COUNT_W-1:0] count_reg, count_next;
    logic               done_reg, done_next;

    // Candidate next words for each bit order, built lane by lane.
    logic [WIDTH-1:0]   shift_lsb;
    logic [WIDTH-1:0]   shift_msb;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            if (gi == WIDTH - 1) begin : g_top
                assign shift_lsb[gi] = bus.serialDataIn;
            end else begin : g_mid_lsb
                assign shift_lsb[gi] = mem_reg[gi+1];
            end
            if (gi == 0) begin : g_bottom
                assign shift_msb[gi] = bus.serialDataIn;
            end else begin : g_mid_msb
                assign shift_msb[gi] = mem_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            mem_reg   <= '0;
            order_reg <= 1'b0;
            count_reg <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            mem_reg   <= mem_next;
            order_reg <= order_next;
            count_reg <= count_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_next   = mem_reg;
        order_next = order_reg;
        count_next = count_reg;
        done_next  = 1'b0;
        // A load wins over a coincident strobe and silently restarts any frame.
        if (bus.parallelLoad) begin
            mem_next   = bus.parallelDataIn;
            order_next = bus.msbFirst;
            count_next = '0;
            state_next = SHIFT;
        end else if (state_reg == SHIFT && bus.peripheralClkEdge) begin
            mem_next   = order_reg ? shift_msb : shift_lsb;
            count_next = count_reg + 1'b1;
            if (count_reg == LAST_COUNT) begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
        end
    end

    assign bus.parallelDataOut = mem_reg;
    assign bus.serialDataOut   = order_reg ? mem_reg[WIDTH-1] : mem_reg[0];
    assign bus.busy            = (state_reg == SHIFT);
    assign bus.frameDone       = done_reg;
endmodule

// File: tb/tb_shift_engine.sv
// Directed-vector bench for shift_engine with an 8-bit and a 16-bit instance.
module tb_shift_engine;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    int   done8   = 0;
    int   done16  = 0;

    always #5 clk = ~clk;

    shift_engine_if #(.WIDTH(8))  bus8 ();
    shift_engine_if #(.WIDTH(16)) bus16 ();

    shift_engine #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));
    shift_engine #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (bus8.frameDone === 1'b1)  done8++;
        if (bus16.frameDone === 1'b1) done16++;
    endtask

    task automatic load8(input logic [7:0] data, input logic order);
        bus8.parallelDataIn = data;
        bus8.msbFirst       = order;
        bus8.parallelLoad   = 1'b1;
        step();
        bus8.parallelLoad   = 1'b0;
    endtask

    task automatic strobe8(input logic sdi);
        bus8.serialDataIn      = sdi;
        bus8.peripheralClkEdge = 1'b1;
        step();
        bus8.peripheralClkEdge = 1'b0;
    endtask

    logic [7:0]  exp_bits;
    logic [7:0]  sdi_pat;
    logic [15:0] word16;
    int          done_before;

    initial begin
        bus8.peripheralClkEdge = 0; bus8.parallelLoad = 0; bus8.parallelDataIn = '0;
        bus8.serialDataIn = 0; bus8.msbFirst = 0;
        bus16.peripheralClkEdge = 0; bus16.parallelLoad = 0; bus16.parallelDataIn = '0;
        bus16.serialDataIn = 0; bus16.msbFirst = 0;

        // Reset state
        #2;
        check("rst_pdo", 32'(bus8.parallelDataOut), 32'h0);
        check("rst_sdo", 32'(bus8.serialDataOut), 32'h0);
        check("rst_busy", 32'(bus8.busy), 32'h0);
        check("rst_done", 32'(bus8.frameDone), 32'h0);
        step(); step();
        reset = 1'b0;
        step();

        // LSB-first frame of 0xA5 shifting in ones; msbFirst toggled mid-frame has no effect
        load8(8'hA5, 1'b0);
        check("lsb_busy_after_load", 32'(bus8.busy), 32'h1);
        check("lsb_pdo_load", 32'(bus8.parallelDataOut), 32'hA5);
        bus8.msbFirst = 1'b1;
        exp_bits = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("lsb_sdo%0d", i), 32'(bus8.serialDataOut), 32'(exp_bits[i]));
            check($sformatf("lsb_done_pre%0d", i), 32'(bus8.frameDone), 32'h0);
            strobe8(1'b1);
        end
        check("lsb_pdo_final", 32'(bus8.parallelDataOut), 32'hFF);
        check("lsb_done_pulse", 32'(bus8.frameDone), 32'h1);
        check("lsb_busy_fall", 32'(bus8.busy), 32'h0);
        step();
        check("lsb_done_one_cycle", 32'(bus8.frameDone), 32'h0);
        check("lsb_done_count", 32'(done8), 32'h1);

        // MSB-first frame of 0xA5 shifting in 0,1,1,0,0,0,1,1
        load8(8'hA5, 1'b1);
        bus8.msbFirst = 1'b0;
        sdi_pat = 8'b0110_0011;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("msb_sdo%0d", i), 32'(bus8.serialDataOut), 32'(exp_bits[7-i]));
            strobe8(sdi_pat[7-i]);
        end
        check("msb_pdo_final", 32'(bus8.parallelDataOut), 32'h63);
        check("msb_done_pulse", 32'(bus8.frameDone), 32'h1);
        check("msb_busy_fall", 32'(bus8.busy), 32'h0);
        step();

        // Load with coincident strobe: strobe ignored, frame still needs 8 strobes
        bus8.serialDataIn      = 1'b1;
        bus8.peripheralClkEdge = 1'b1;
        load8(8'h3C, 1'b0);
        bus8.peripheralClkEdge = 1'b0;
        check("ld_strobe_pdo", 32'(bus8.parallelDataOut), 32'h3C);
        for (int i = 0; i < 7; i++) strobe8(1'b1);
        check("ld_strobe_busy7", 32'(bus8.busy), 32'h1);
        check("ld_strobe_done7", 32'(bus8.frameDone), 32'h0);
        strobe8(1'b1);
        check("ld_strobe_done8", 32'(bus8.frameDone), 32'h1);
        check("ld_strobe_pdo8", 32'(bus8.parallelDataOut), 32'hFF);
        strobe8(1'b0);
        check("idle_strobe_hold", 32'(bus8.parallelDataOut), 32'hFF);
        check("idle_strobe_busy", 32'(bus8.busy), 32'h0);

        // Abort with reload after 3 strobes
        done_before = done8;
        load8(8'hF0, 1'b0);
        for (int i = 0; i < 3; i++) strobe8(1'b0);
        check("abort_pdo3", 32'(bus8.parallelDataOut), 32'h1E);
        load8(8'h0F, 1'b0);
        check("abort_pdo_reload", 32'(bus8.parallelDataOut), 32'h0F);
        check("abort_busy", 32'(bus8.busy), 32'h1);
        for (int i = 0; i < 7; i++) strobe8(1'b0);
        check("abort_no_done", 32'(done8 - done_before), 32'h0);
        check("abort_busy7", 32'(bus8.busy), 32'h1);
        strobe8(1'b0);
        check("abort_done8", 32'(bus8.frameDone), 32'h1);
        check("abort_pdo8", 32'(bus8.parallelDataOut), 32'h00);
        step();

        // Mid-frame asynchronous reset
        done_before = done8;
        load8(8'h5A, 1'b1);
        for (int i = 0; i < 4; i++) strobe8(1'b1);
        check("rstmid_pdo4", 32'(bus8.parallelDataOut), 32'hAF);
        check("rstmid_sdo4", 32'(bus8.serialDataOut), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("rstmid_pdo", 32'(bus8.parallelDataOut), 32'h0);
        check("rstmid_sdo", 32'(bus8.serialDataOut), 32'h0);
        check("rstmid_busy", 32'(bus8.busy), 32'h0);
        check("rstmid_done", 32'(bus8.frameDone), 32'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) strobe8(1'b1);
        check("rstmid_no_done", 32'(done8 - done_before), 32'h0);
        check("rstmid_idle_hold", 32'(bus8.parallelDataOut), 32'h0);
        load8(8'hC3, 1'b0);
        check("rstmid_reload_pdo", 32'(bus8.parallelDataOut), 32'hC3);
        check("rstmid_reload_busy", 32'(bus8.busy), 32'h1);
        check("rstmid_reload_sdo", 32'(bus8.serialDataOut), 32'h1);

        // 16-bit instance, MSB first, strobes spaced 10 clocks apart
        word16 = 16'h1234;
        bus16.parallelDataIn = word16;
        bus16.msbFirst       = 1'b1;
        bus16.parallelLoad   = 1'b1;
        step();
        bus16.parallelLoad   = 1'b0;
        bus16.msbFirst       = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("w16_sdo%0d", i), 32'(bus16.serialDataOut), 32'(word16[15-i]));
            check($sformatf("w16_busy%0d", i), 32'(bus16.busy), 32'h1);
            bus16.serialDataIn      = word16[15-i];
            bus16.peripheralClkEdge = 1'b1;
            step();
            bus16.peripheralClkEdge = 1'b0;
            if (i < 15) begin
                check($sformatf("w16_nodone%0d", i), 32'(bus16.frameDone), 32'h0);
                for (int g = 0; g < 9; g++) step();
            end
        end
        check("w16_done", 32'(bus16.frameDone), 32'h1);
        check("w16_busy_fall", 32'(bus16.busy), 32'h0);
        check("w16_pdo", 32'(bus16.parallelDataOut), 32'h1234);
        step();
        check("w16_done_count", 32'(done16), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
